// File: rtl/gpio_arbiter_if.sv
// Bundle of both requester ports plus the shared GPIO register port.
// slave: arbiter side; master: requesters and GPIO model side.
interface gpio_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_lock;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  data_i,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output we_o, addr_o, data_o
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output data_i,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  we_o, addr_o, data_o
  );
endinterface

// File: rtl/gpio_arbiter.sv
// Two-master round-robin arbiter onto one GPIO register port, with lock for RMW and idle timeout.
// Access presented in the grant cycle, read data one cycle later; a losing master just sees gnt=0.
module gpio_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rstn,
  gpio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] TMO = LOCK_TIMEOUT[7:0];

  state_t     state;
  logic       prio;
  logic [7:0] idle_cnt;
  logic [7:0] cnt_inc;
  logic       timeout;
  logic       gnt0;
  logic       gnt1;
  logic       any_gnt;
  logic       gnt_lock;

  // Grants are masked by reset so nothing reaches the GPIO while rstn is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      case (state)
        IDLE: begin
          if (bus.m0_req && (!bus.m1_req || !prio)) gnt0 = 1'b1;
          else if (bus.m1_req)                      gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = bus.m0_req;
        LOCK1:   gnt1 = bus.m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_lock = gnt1 ? bus.m1_lock : bus.m0_lock;
  assign cnt_inc  = idle_cnt + 8'd1;
  assign timeout  = (cnt_inc == TMO);

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.we_o   = gnt1 ? bus.m1_we    : (gnt0 & bus.m0_we);
  assign bus.addr_o = gnt1 ? bus.m1_addr  : bus.m0_addr;
  assign bus.data_o = gnt1 ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      prio          <= 1'b0;
      idle_cnt      <= 8'd0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= 32'd0;
      bus.m1_rdata  <= 32'd0;
    end else begin
      bus.m0_rvalid <= gnt0 & ~bus.m0_we;
      bus.m1_rvalid <= gnt1 & ~bus.m1_we;
      if (gnt0 && !bus.m0_we) bus.m0_rdata <= bus.data_i;
      if (gnt1 && !bus.m1_we) bus.m1_rdata <= bus.data_i;

      case (state)
        IDLE: begin
          idle_cnt <= 8'd0;
          if (any_gnt) begin
            // A locking grant keeps prio so the round-robin resumes fairly afterwards.
            if (gnt_lock) state <= gnt0 ? LOCK0 : LOCK1;
            else          prio  <= gnt0;
          end
        end
        LOCK0, LOCK1: begin
          if (any_gnt) begin
            idle_cnt <= 8'd0;
            if (!gnt_lock) begin
              state <= IDLE;
              prio  <= gnt0;
            end
          end else if (timeout) begin
            state    <= IDLE;
            prio     <= (state == LOCK0);
            idle_cnt <= 8'd0;
          end else begin
            idle_cnt <= cnt_inc;
          end
        end
        default: begin
          state    <= IDLE;
          idle_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: vector table, directed corner sequences and random traffic
// compared every cycle against an ownership/priority model of the arbitration rules.
module tb_gpio_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req[2];
  logic        we[2];
  logic        lock[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [31:0] din;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: owner (-1 = nobody), round-robin priority, idle cycles, pending read results.
  int          m_owner;
  int          m_prio;
  int          m_idle;
  logic        m_rv[2];
  logic [31:0] m_rd[2];

  typedef struct {
    logic r0, r1, w0, w1, l0, l1, g0, g1;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  gpio_arbiter_if bus();

  assign bus.m0_req   = req[0];
  assign bus.m1_req   = req[1];
  assign bus.m0_we    = we[0];
  assign bus.m1_we    = we[1];
  assign bus.m0_lock  = lock[0];
  assign bus.m1_lock  = lock[1];
  assign bus.m0_addr  = addr[0];
  assign bus.m1_addr  = addr[1];
  assign bus.m0_wdata = wdata[0];
  assign bus.m1_wdata = wdata[1];
  assign bus.data_i   = din;

  gpio_arbiter #(.LOCK_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_idle  = 0;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    m_rd[0] = 32'd0;
    m_rd[1] = 32'd0;
  endtask

  function automatic int model_grant();
    if (m_owner < 0) begin
      if (req[0] && req[1]) return m_prio;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
    end
    return req[m_owner] ? m_owner : -1;
  endfunction

  task automatic model_edge();
    int g;
    g = model_grant();
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (g >= 0 && !we[g]) begin
      m_rv[g] = 1'b1;
      m_rd[g] = din;
    end
    if (g >= 0) begin
      m_idle = 0;
      if (lock[g]) m_owner = g;
      else begin
        m_owner = -1;
        m_prio  = 1 - g;
      end
    end else if (m_owner >= 0) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
        m_idle  = 0;
      end
    end
  endtask

  task automatic compare_model();
    int g;
    g = model_grant();
    chk("gnt0",    32'(bus.m0_gnt),    32'(g == 0));
    chk("gnt1",    32'(bus.m1_gnt),    32'(g == 1));
    chk("we_o",    32'(bus.we_o),      32'((g >= 0) ? we[g] : 1'b0));
    chk("addr_o",  bus.addr_o,         (g == 1) ? addr[1] : addr[0]);
    chk("data_o",  bus.data_o,         (g == 1) ? wdata[1] : wdata[0]);
    chk("rvalid0", 32'(bus.m0_rvalid), 32'(m_rv[0]));
    chk("rvalid1", 32'(bus.m1_rvalid), 32'(m_rv[1]));
    chk("rdata0",  bus.m0_rdata,       m_rd[0]);
    chk("rdata1",  bus.m1_rdata,       m_rd[1]);
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      req[i]  = 1'b0;
      we[i]   = 1'b0;
      lock[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    addr[0] = 32'h0; addr[1] = 32'h4;
    wdata[0] = 32'hA0A0_0001; wdata[1] = 32'hB1B1_0002;
    din = 32'h0000_0003;

    // Reset state, including grant masking with requests already pending.
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    #2;
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b1;
    #1;
    chk("rst_gnt0",    32'(bus.m0_gnt),    32'd0);
    chk("rst_gnt1",    32'(bus.m1_gnt),    32'd0);
    chk("rst_we_o",    32'(bus.we_o),      32'd0);
    chk("rst_rvalid0", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_rdata1",  bus.m1_rdata,       32'd0);
    do_reset();

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      req[0] = tbl[i].r0; req[1] = tbl[i].r1;
      we[0]  = tbl[i].w0; we[1]  = tbl[i].w1;
      lock[0] = tbl[i].l0; lock[1] = tbl[i].l1;
      sample_point();
      chk($sformatf("tbl%0d_g0", i), 32'(bus.m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_g1", i), 32'(bus.m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_we", i), 32'(bus.we_o),
          32'(tbl[i].g0 ? tbl[i].w0 : (tbl[i].g1 ? tbl[i].w1 : 1'b0)));
      compare_model();
      advance();
    end

    // Both read 0x4 right after reset.
    do_reset();
    addr[0] = 32'h4; addr[1] = 32'h4; din = 32'h3;
    req[0] = 1'b1; req[1] = 1'b1;
    sample_point();
    chk("rd_c1_gnt0", 32'(bus.m0_gnt), 32'd1);
    compare_model();
    advance();
    req[0] = 1'b0;
    sample_point();
    chk("rd_c2_rvalid0", 32'(bus.m0_rvalid), 32'd1);
    chk("rd_c2_rdata0",  bus.m0_rdata,       32'h3);
    chk("rd_c2_gnt1",    32'(bus.m1_gnt),    32'd1);
    compare_model();
    advance();
    req[1] = 1'b0;
    sample_point();
    chk("rd_c3_rvalid1", 32'(bus.m1_rvalid), 32'd1);
    chk("rd_c3_rdata1",  bus.m1_rdata,       32'h3);
    compare_model();
    advance();

    // Streaming writes, strict alternation.
    do_reset();
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata[0] = 32'h1000 + 32'(i); wdata[1] = 32'h2000 + 32'(i);
      sample_point();
      chk($sformatf("wr%0d_gnt0", i), 32'(bus.m0_gnt), 32'(i % 2 == 0));
      chk($sformatf("wr%0d_data", i), bus.data_o, (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
      chk($sformatf("wr%0d_we", i), 32'(bus.we_o), 32'd1);
      compare_model();
      advance();
    end

    // Locked read-modify-write by m0 with m1 waiting.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; lock[0] = 1'b1; addr[0] = 32'h4;
    req[1] = 1'b1; we[1] = 1'b0;
    sample_point();
    chk("rmw_c1_gnt0", 32'(bus.m0_gnt), 32'd1);
    chk("rmw_c1_gnt1", 32'(bus.m1_gnt), 32'd0);
    compare_model();
    advance();
    we[0] = 1'b1; lock[0] = 1'b0; wdata[0] = 32'h1;
    sample_point();
    chk("rmw_c2_gnt0", 32'(bus.m0_gnt), 32'd1);
    chk("rmw_c2_gnt1", 32'(bus.m1_gnt), 32'd0);
    compare_model();
    advance();
    req[0] = 1'b0;
    sample_point();
    chk("rmw_c3_gnt1", 32'(bus.m1_gnt), 32'd1);
    compare_model();
    advance();
    idle_inputs();

    // Lock timeout: m1 locks then goes quiet; m0 must win after exactly TMO+1 cycles.
    do_reset();
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1;
    sample_point();
    chk("to_lock_gnt1", 32'(bus.m1_gnt), 32'd1);
    compare_model();
    advance();
    req[1] = 1'b0; req[0] = 1'b1; we[0] = 1'b1;
    for (int k = 1; k <= TMO + 1; k++) begin
      // m1 re-requests on the expected release cycle: prio 0 must still favour m0.
      req[1] = (k == TMO + 1);
      sample_point();
      chk($sformatf("to_k%0d_gnt0", k), 32'(bus.m0_gnt), 32'(k == TMO + 1));
      chk($sformatf("to_k%0d_gnt1", k), 32'(bus.m1_gnt), 32'd0);
      compare_model();
      advance();
    end
    req[0] = 1'b0;
    sample_point();
    chk("to_after_gnt1", 32'(bus.m1_gnt), 32'd1);
    compare_model();
    advance();
    idle_inputs();

    // Asynchronous reset in LOCK0 with a read result pending.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; lock[0] = 1'b1; addr[0] = 32'h4; din = 32'h5;
    sample_point();
    compare_model();
    advance();
    we[0] = 1'b1; wdata[0] = 32'hDEAD_BEEF;
    sample_point();
    chk("ar_pre_rvalid0", 32'(bus.m0_rvalid), 32'd1);
    chk("ar_pre_we",      32'(bus.we_o),      32'd1);
    compare_model();
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_rvalid0", 32'(bus.m0_rvalid), 32'd0);
    chk("ar_rdata0",  bus.m0_rdata,       32'd0);
    chk("ar_gnt0",    32'(bus.m0_gnt),    32'd0);
    chk("ar_we",      32'(bus.we_o),      32'd0);
    model_reset();
    @(posedge clk);
    #1;
    req[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0; lock[1] = 1'b0; din = 32'h77;
    rstn = 1'b1;
    sample_point();
    chk("ar_post_gnt1", 32'(bus.m1_gnt), 32'd1);
    compare_model();
    advance();
    req[1] = 1'b0;
    sample_point();
    chk("ar_post_rdata1", bus.m1_rdata, 32'h77);
    compare_model();
    advance();

    // Random traffic, requests held until granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int pct;
      int g;
      pct = ((c / 100) % 2 == 1) ? 8 : 70;
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          req[i]   = ($urandom_range(99) < pct);
          we[i]    = 1'($urandom_range(1));
          lock[i]  = ($urandom_range(99) < 30);
          addr[i]  = $urandom_range(1) ? 32'h4 : 32'h0;
          wdata[i] = $urandom;
        end
      end
      din = $urandom;
      sample_point();
      compare_model();
      g = model_grant();
      advance();
      if (g >= 0) req[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 16: idle cycles after which a locked owner loses ownership; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 mN_req  input  1  (N=0,1) requester N has an access pending; held until mN_gnt.
REQ-005 mN_we  input  1  access is a write (1) or a read (0).
REQ-006 mN_addr  input  32  GPIO register address (0x0 ctrl, 0x4 data).
REQ-007 mN_wdata  input  32  write data.
REQ-008 mN_lock  input  1  keep ownership after this access (read-modify-write sequences).
REQ-009 mN_gnt  output  1  access is presented to the GPIO in this cycle.
REQ-010 mN_rvalid  output  1  read data valid; one-cycle pulse.
REQ-011 mN_rdata  output  32  read data, registered.
REQ-012 we_o  output  1  GPIO write enable.
REQ-013 addr_o  output  32  GPIO address.
REQ-014 data_o  output  32  GPIO write data.
REQ-015 data_i  input  32  GPIO combinational read data for addr_o.

Function
REQ-016 States: IDLE (no owner), LOCK0 (master 0 owns), LOCK1 (master 1 owns).
REQ-017 At most one mN_gnt is high in any cycle.
REQ-018 mN_gnt is combinational from current req/state/pointer; the access is presented in the same cycle as the grant: we_o=mN_we & mN_gnt, addr_o=mN_addr, data_o=mN_wdata of the granted master.
REQ-019 No grant: we_o=0; addr_o and data_o hold the value of master 0 (don't-care for the GPIO).
REQ-020 IDLE, one req: that master is granted.
REQ-021 IDLE, both req: the master named by the 1-bit round-robin pointer prio is granted.
REQ-022 After every grant in IDLE with mN_lock=0, prio becomes the other master; the state stays IDLE.
REQ-023 Grant in IDLE with mN_lock=1: next state LOCKN; prio is unchanged.
REQ-024 LOCKN: only master N can be granted; the other master's req is stalled (gnt=0).
REQ-025 LOCKN: a granted access with mN_lock=0 is the last one. Next state IDLE; prio = other master.
REQ-026 LOCKN: an 8-bit idle counter clears on each owner grant and increments each cycle without one.
REQ-027 In LOCKN, when the counter reaches LOCK_TIMEOUT and the owner does not req in that cycle: next state IDLE, prio = other master, counter cleared.
REQ-028 If the owner reqs in the same cycle the counter reaches LOCK_TIMEOUT, it is granted and the counter clears; the grant wins over the timeout.
REQ-029 Read (granted, we=0): data_i is captured into mN_rdata at the grant edge. mN_rvalid pulses high in the next cycle. Read latency is 1 cycle.
REQ-030 Write (granted, we=1): the GPIO updates at the grant edge. No rvalid is produced. mN_rdata holds its previous value.
REQ-031 mN_rdata of the non-granted master is never modified.
REQ-032 Back-to-back grants to the same or the alternating master are allowed every cycle; there are no bubbles.
REQ-033 Throughput with both masters requesting continuously and lock=0: strict alternation, one access per cycle.

Reset
REQ-034 rstn low asynchronously forces the following, regardless of clk: state IDLE, prio=0, counter=0, mN_rvalid=0, mN_rdata=0.
REQ-035 While rstn is low: mN_gnt=0 and we_o=0, whatever the requests.
REQ-036 Reset during LOCKN or with a read outstanding drops the ownership and the pending rvalid. No GPIO write is issued in the reset cycle.
REQ-037 After rstn deasserts, the first rising edge behaves as IDLE with prio=0.

Verification
REQ-038 Scenario: after reset, both masters req reads of 0x4 with data_i=0x00000003.
- Cycle 1: m0_gnt. Cycle 2: m0_rvalid with m0_rdata=0x3, and m1_gnt. Cycle 3: m1_rvalid.
REQ-039 Scenario: both masters stream writes with lock=0 for 6 cycles.
- Grants alternate m0, m1, m0, m1, m0, m1.
- we_o=1 every cycle; data_o follows the granted master.
REQ-040 Scenario: m0 reads 0x4 with lock=1, then writes 0x4 = 0x1 with lock=0, while m1_req is held high throughout.
- m1 gets no grant until the cycle after the m0 write.
- m1 is then granted.
REQ-041 Scenario: m1 acquires the lock, then stops requesting; LOCK_TIMEOUT=16, m0_req high.
- m0 is granted exactly 17 cycles after m1's last grant.
- The state returns to IDLE with prio=0.
REQ-042 Scenario: rstn is pulled low mid-cycle while in LOCK0, one cycle after a read grant.
- m0_rvalid, the gnts and we_o go 0 immediately.
- After release, m1 alone requesting is granted on the first edge.
